// File: rtl/ip_packet_pkg.sv
// ============================================================================
// Module      : ip_packet_pkg
// Description : Frame layout constants and the receive state encoding shared
//               by the IP packet transmitter and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ip_packet_pkg;

    localparam int ETH_HDR_SIZE_BYTES   = 14;
    localparam int IP_HDR_SIZE_BYTES    = 20;
    localparam int FRAME_CHECKSUM_BYTES = 4;
    localparam int DATA_SIZE_BYTES      = 26;

    localparam logic [15:0] ETH_TYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  IP_VERSION_IHL = 8'h45;

    typedef enum logic [2:0] {
        RECV_ETH_HDR   = 3'd0,
        RECV_IP_HDR    = 3'd1,
        RECV_USER_DATA = 3'd2,
        DROP           = 3'd3,
        HOLD_RESULT    = 3'd4
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/ip_checksum_accumulator.sv
// ============================================================================
// Module      : ip_checksum_accumulator
// Description : One's-complement sum of a byte stream taken as big-endian
//               16-bit words; o_sum already includes the word completed by
//               the current byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ip_checksum_accumulator (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    input  logic        i_clear,
    output logic [15:0] o_sum
);

    logic        r_odd;
    logic [7:0]  r_hi;
    logic [15:0] r_acc;
    logic [16:0] w_raw;
    logic [15:0] w_folded;

    // End-around carry: a single fold suffices since the wrapped sum cannot overflow again.
    assign w_raw    = {1'b0, r_acc} + {1'b0, r_hi, i_data};
    assign w_folded = w_raw[15:0] + {15'd0, w_raw[16]};
    assign o_sum    = (i_valid && r_odd) ? w_folded : r_acc;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_odd <= 1'b0;
            r_hi  <= 8'h00;
            r_acc <= 16'h0000;
        end else if (i_valid) begin
            if (r_odd) begin
                r_acc <= w_folded;
            end else begin
                r_hi <= i_data;
            end
            r_odd <= ~r_odd;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ip_packet_rx.sv
// ============================================================================
// Module      : ip_packet_rx
// Description : Parses Ethernet/IPv4/user-data frames from a byte stream,
//               presents sender MAC/IP and message with valid/accept, and
//               counts dropped frames. Define IP_RX_CHECKSUM_CHECK_EN to
//               also reject frames with a bad IPv4 header checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ip_packet_rx
    import ip_packet_pkg::*;
#(
    parameter int AXI_S_DATA_WIDTH = 8,
    parameter int IP_ADDR_WIDTH    = 32,
    parameter int MAC_ADDR_WIDTH   = 48,
    parameter int ACCEL_DATA_WIDTH = 10,
    parameter int DROP_CNT_WIDTH   = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [MAC_ADDR_WIDTH-1:0]   ACCELERATOR_MAC_ADDRESS,
    input  logic [AXI_S_DATA_WIDTH-1:0] MAC_DATA_IN,
    input  logic                        MAC_DATA_VALID,
    output logic                        MAC_DATA_READY,
    input  logic                        MAC_DATA_LAST,
    input  logic                        MAC_DATA_TUSER,
    output logic [MAC_ADDR_WIDTH-1:0]   SENDER_MAC_ADDRESS,
    output logic [IP_ADDR_WIDTH-1:0]    SENDER_IP_ADDRESS,
    output logic [ACCEL_DATA_WIDTH-1:0] SENDER_MESSAGE,
    output logic                        MESSAGE_VALID,
    input  logic                        MESSAGE_ACCEPT,
    output logic [DROP_CNT_WIDTH-1:0]   FRAMES_DROPPED
);

    localparam logic [7:0] c_ETH_LAST     = 8'(ETH_HDR_SIZE_BYTES - 1);
    localparam logic [7:0] c_IP_LAST      = 8'(IP_HDR_SIZE_BYTES - 1);
    localparam logic [7:0] c_MAC_BYTES    = 8'd6;
    localparam logic [7:0] c_ETH_TYPE_POS = 8'd12;
    localparam logic [7:0] c_IP_SRC_FIRST = 8'd12;
    localparam logic [7:0] c_IP_SRC_END   = 8'd16;
    localparam logic [DROP_CNT_WIDTH-1:0] c_DROP_MAX = '1;

    rx_state_t                   r_state;
    logic [7:0]                  r_cnt;
    logic                        r_bad, r_not_own, r_not_bcast;
    logic [MAC_ADDR_WIDTH-1:0]   r_shadow_mac;
    logic [IP_ADDR_WIDTH-1:0]    r_shadow_ip;
    logic [1:0]                  r_msg_hi;
    logic [7:0]                  r_msg_lo;
    logic                        r_ready, r_valid;
    logic [MAC_ADDR_WIDTH-1:0]   r_sender_mac;
    logic [IP_ADDR_WIDTH-1:0]    r_sender_ip;
    logic [ACCEL_DATA_WIDTH-1:0] r_sender_msg;
    logic [DROP_CNT_WIDTH-1:0]   r_dropped;

    logic                        w_beat, w_eth_type_bad, w_eth_reject, w_ip_ver_bad, w_csum_bad;
    logic [7:0]                  w_cnt_next, w_own_byte;
    logic [DROP_CNT_WIDTH-1:0]   w_drop_next;

    assign w_beat      = MAC_DATA_VALID && r_ready;
    assign w_cnt_next  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_drop_next = (r_dropped == c_DROP_MAX) ? r_dropped : r_dropped + 1'b1;

    always_comb begin
        w_own_byte = 8'h00;
        case (r_cnt[2:0])
            3'd0:    w_own_byte = ACCELERATOR_MAC_ADDRESS[7:0];
            3'd1:    w_own_byte = ACCELERATOR_MAC_ADDRESS[15:8];
            3'd2:    w_own_byte = ACCELERATOR_MAC_ADDRESS[23:16];
            3'd3:    w_own_byte = ACCELERATOR_MAC_ADDRESS[31:24];
            3'd4:    w_own_byte = ACCELERATOR_MAC_ADDRESS[39:32];
            3'd5:    w_own_byte = ACCELERATOR_MAC_ADDRESS[47:40];
            default: w_own_byte = 8'h00;
        endcase
    end

    // Destination is rejected only if it matches neither our address nor broadcast as a whole.
    assign w_eth_type_bad = ((r_cnt == c_ETH_TYPE_POS) && (MAC_DATA_IN != ETH_TYPE_IPV4[15:8])) ||
                            ((r_cnt == c_ETH_LAST)     && (MAC_DATA_IN != ETH_TYPE_IPV4[7:0]));
    assign w_eth_reject   = r_bad || w_eth_type_bad || (r_not_own && r_not_bcast);
    assign w_ip_ver_bad   = (r_cnt == 8'd0) && (MAC_DATA_IN != IP_VERSION_IHL);

`ifdef IP_RX_CHECKSUM_CHECK_EN
    logic [15:0] w_csum_sum;

    ip_checksum_accumulator u_csum (
        .clk     (ACLK),
        .rst     (ARESET),
        .i_data  (MAC_DATA_IN),
        .i_valid (w_beat && (r_state == RECV_IP_HDR)),
        .i_clear (r_state != RECV_IP_HDR),
        .o_sum   (w_csum_sum)
    );

    assign w_csum_bad = (r_cnt == c_IP_LAST) && (w_csum_sum != 16'hFFFF);
`else
    assign w_csum_bad = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state      <= RECV_ETH_HDR;
            r_cnt        <= 8'd0;
            r_bad        <= 1'b0;
            r_not_own    <= 1'b0;
            r_not_bcast  <= 1'b0;
            r_shadow_mac <= '0;
            r_shadow_ip  <= '0;
            r_msg_hi     <= 2'd0;
            r_msg_lo     <= 8'd0;
            r_ready      <= 1'b1;
            r_valid      <= 1'b0;
            r_sender_mac <= '0;
            r_sender_ip  <= '0;
            r_sender_msg <= '0;
            r_dropped    <= '0;
        end else begin
            case (r_state)
                RECV_ETH_HDR: if (w_beat) begin
                    if (r_cnt < c_MAC_BYTES) begin
                        if (MAC_DATA_IN != w_own_byte) r_not_own   <= 1'b1;
                        if (MAC_DATA_IN != 8'hFF)      r_not_bcast <= 1'b1;
                    end else if (r_cnt < c_ETH_TYPE_POS) begin
                        r_shadow_mac <= {MAC_DATA_IN, r_shadow_mac[MAC_ADDR_WIDTH-1:8]};
                    end
                    if (w_eth_type_bad) r_bad <= 1'b1;
                    if (MAC_DATA_LAST) begin
                        r_dropped   <= w_drop_next;
                        r_cnt       <= 8'd0;
                        r_bad       <= 1'b0;
                        r_not_own   <= 1'b0;
                        r_not_bcast <= 1'b0;
                    end else if (r_cnt == c_ETH_LAST) begin
                        r_state <= w_eth_reject ? DROP : RECV_IP_HDR;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                RECV_IP_HDR: if (w_beat) begin
                    if (w_ip_ver_bad) r_bad <= 1'b1;
                    if (r_cnt >= c_IP_SRC_FIRST && r_cnt < c_IP_SRC_END)
                        r_shadow_ip <= {MAC_DATA_IN, r_shadow_ip[IP_ADDR_WIDTH-1:8]};
                    if (MAC_DATA_LAST) begin
                        r_dropped   <= w_drop_next;
                        r_state     <= RECV_ETH_HDR;
                        r_cnt       <= 8'd0;
                        r_bad       <= 1'b0;
                        r_not_own   <= 1'b0;
                        r_not_bcast <= 1'b0;
                    end else if (r_cnt == c_IP_LAST) begin
                        r_state <= (r_bad || w_ip_ver_bad || w_csum_bad) ? DROP : RECV_USER_DATA;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                RECV_USER_DATA: if (w_beat) begin
                    if (r_cnt == 8'd0) r_msg_hi <= MAC_DATA_IN[1:0];
                    if (r_cnt == 8'd1) r_msg_lo <= MAC_DATA_IN;
                    if (MAC_DATA_LAST) begin
                        r_cnt       <= 8'd0;
                        r_bad       <= 1'b0;
                        r_not_own   <= 1'b0;
                        r_not_bcast <= 1'b0;
                        if (MAC_DATA_TUSER || r_cnt == 8'd0) begin
                            r_dropped <= w_drop_next;
                            r_state   <= RECV_ETH_HDR;
                        end else begin
                            // A two-byte payload ends on the low message byte itself.
                            r_sender_mac <= r_shadow_mac;
                            r_sender_ip  <= r_shadow_ip;
                            r_sender_msg <= {r_msg_hi, (r_cnt == 8'd1) ? MAC_DATA_IN : r_msg_lo};
                            r_valid      <= 1'b1;
                            r_ready      <= 1'b0;
                            r_state      <= HOLD_RESULT;
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                DROP: if (w_beat) begin
                    if (MAC_DATA_LAST) begin
                        r_dropped   <= w_drop_next;
                        r_state     <= RECV_ETH_HDR;
                        r_cnt       <= 8'd0;
                        r_bad       <= 1'b0;
                        r_not_own   <= 1'b0;
                        r_not_bcast <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                HOLD_RESULT: if (MESSAGE_ACCEPT) begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= RECV_ETH_HDR;
                end
                default: r_state <= RECV_ETH_HDR;
            endcase
        end
    end

    assign MAC_DATA_READY     = r_ready;
    assign MESSAGE_VALID      = r_valid;
    assign SENDER_MAC_ADDRESS = r_sender_mac;
    assign SENDER_IP_ADDRESS  = r_sender_ip;
    assign SENDER_MESSAGE     = r_sender_msg;
    assign FRAMES_DROPPED     = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_ip_packet_rx.sv
// ============================================================================
// Module      : tb_ip_packet_rx
// Description : Directed and random frames for ip_packet_rx, checked against
//               a frame-level reference model (honours IP_RX_CHECKSUM_CHECK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ip_packet_rx;

    localparam logic [47:0] c_ACCEL_MAC = 48'h5E4D3C2B1A02;
    localparam logic [47:0] c_NOM_SRC   = 48'h665544332211;
    localparam logic [31:0] c_NOM_IP    = 32'h0700A8C0;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  MAC_DATA_IN;
    logic        MAC_DATA_VALID, MAC_DATA_READY, MAC_DATA_LAST, MAC_DATA_TUSER;
    logic [47:0] SENDER_MAC_ADDRESS;
    logic [31:0] SENDER_IP_ADDRESS;
    logic [9:0]  SENDER_MESSAGE;
    logic        MESSAGE_VALID, MESSAGE_ACCEPT;
    logic [15:0] FRAMES_DROPPED;

    always #5 ACLK = ~ACLK;

    ip_packet_rx dut (
        .ACLK                    (ACLK),
        .ARESET                  (ARESET),
        .ACCELERATOR_MAC_ADDRESS (c_ACCEL_MAC),
        .MAC_DATA_IN             (MAC_DATA_IN),
        .MAC_DATA_VALID          (MAC_DATA_VALID),
        .MAC_DATA_READY          (MAC_DATA_READY),
        .MAC_DATA_LAST           (MAC_DATA_LAST),
        .MAC_DATA_TUSER          (MAC_DATA_TUSER),
        .SENDER_MAC_ADDRESS      (SENDER_MAC_ADDRESS),
        .SENDER_IP_ADDRESS       (SENDER_IP_ADDRESS),
        .SENDER_MESSAGE          (SENDER_MESSAGE),
        .MESSAGE_VALID           (MESSAGE_VALID),
        .MESSAGE_ACCEPT          (MESSAGE_ACCEPT),
        .FRAMES_DROPPED          (FRAMES_DROPPED)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  frm[$];
    logic [47:0] exp_mac = '0;
    logic [31:0] exp_ip  = '0;
    logic [9:0]  exp_msg = '0;
    int          exp_dropped = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ip_sum();
        logic [16:0] s;
        s = '0;
        for (int k = 0; k < 10; k++) begin
            s = {1'b0, s[15:0]} + {1'b0, frm[14 + 2*k], frm[15 + 2*k]};
            s = {1'b0, s[15:0] + {15'd0, s[16]}};
        end
        return s[15:0];
    endfunction

    // Frame-level reference: accept iff long enough, addressed to us, IPv4, clean.
    function automatic bit model_accept(input bit tuser, output logic [47:0] mac,
                                        output logic [31:0] ip, output logic [9:0] msg);
        bit own, bc;
        own = 1'b1; bc = 1'b1;
        mac = '0; ip = '0; msg = '0;
        if (frm.size() < 36) return 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (frm[i] != c_ACCEL_MAC[8*i +: 8]) own = 1'b0;
            if (frm[i] != 8'hFF) bc = 1'b0;
        end
        if (!(own || bc)) return 1'b0;
        if (frm[12] != 8'h08 || frm[13] != 8'h00) return 1'b0;
        if (frm[14] != 8'h45) return 1'b0;
`ifdef IP_RX_CHECKSUM_CHECK_EN
        if (ip_sum() != 16'hFFFF) return 1'b0;
`endif
        if (tuser) return 1'b0;
        for (int i = 0; i < 6; i++) mac[8*i +: 8] = frm[6 + i];
        for (int i = 0; i < 4; i++) ip[8*i +: 8] = frm[26 + i];
        msg = {frm[34][1:0], frm[35]};
        return 1'b1;
    endfunction

    task automatic build_frame(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] etype,
                               input logic [7:0] vihl, input logic [31:0] sip, input logic [9:0] msg,
                               input int len, input bit bad_csum, input bit rnd);
        logic [15:0] c;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dest[8*i +: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(src[8*i +: 8]);
        frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
        frm.push_back(vihl);  frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h2E);
        frm.push_back(8'h12); frm.push_back(8'h34); frm.push_back(8'h40); frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(8'h11); frm.push_back(8'h00); frm.push_back(8'h00);
        for (int i = 0; i < 4; i++) frm.push_back(sip[8*i +: 8]);
        frm.push_back(8'h0A); frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h01);
        c = ~ip_sum();
        frm[24] = c[15:8] ^ (bad_csum ? 8'h01 : 8'h00);
        frm[25] = c[7:0];
        frm.push_back({rnd ? 6'($urandom) : 6'd0, msg[9:8]});
        frm.push_back(msg[7:0]);
        for (int i = 0; i < 24; i++) frm.push_back(rnd ? 8'($urandom) : 8'h00);
        while (frm.size() > len) void'(frm.pop_back());
        while (frm.size() < len) frm.push_back(rnd ? 8'($urandom) : 8'h00);
    endtask

    task automatic send_frame(input bit tuser, input bit gaps, input bit nolast);
        bit lst;
        int guard;
        for (int i = 0; i < frm.size(); i++) begin
            lst = !nolast && (i == frm.size() - 1);
            if (gaps && $urandom_range(0, 3) == 0) begin
                MAC_DATA_VALID = 1'b0;
                MAC_DATA_IN    = 8'($urandom);
                @(posedge ACLK); #1;
            end
            MAC_DATA_IN    = frm[i];
            MAC_DATA_VALID = 1'b1;
            MAC_DATA_LAST  = lst;
            MAC_DATA_TUSER = lst ? tuser : 1'($urandom);
            MESSAGE_ACCEPT = 1'($urandom);
            guard = 0;
            while (!MAC_DATA_READY && guard < 20) begin
                @(posedge ACLK); #1;
                guard++;
            end
            if (guard == 20) chk("ready_wait", 64'(MAC_DATA_READY), 64'd1);
            @(posedge ACLK); #1;
        end
        MAC_DATA_VALID = 1'b0;
        MAC_DATA_LAST  = 1'b0;
        MAC_DATA_TUSER = 1'b0;
        MESSAGE_ACCEPT = 1'b0;
    endtask

    task automatic run_frame(input bit tuser, input bit gaps, input string tag);
        bit          acc;
        logic [47:0] m;
        logic [31:0] ip;
        logic [9:0]  msg;
        int          w;
        send_frame(tuser, gaps, 1'b0);
        acc = model_accept(tuser, m, ip, msg);
        if (acc) begin
            exp_mac = m; exp_ip = ip; exp_msg = msg;
        end else begin
            exp_dropped++;
        end
        chk({tag, "_valid"},   64'(MESSAGE_VALID),      64'(acc));
        chk({tag, "_ready"},   64'(MAC_DATA_READY),     64'(!acc));
        chk({tag, "_dropped"}, 64'(FRAMES_DROPPED),     64'(exp_dropped));
        chk({tag, "_mac"},     64'(SENDER_MAC_ADDRESS), 64'(exp_mac));
        chk({tag, "_ip"},      64'(SENDER_IP_ADDRESS),  64'(exp_ip));
        chk({tag, "_msg"},     64'(SENDER_MESSAGE),     64'(exp_msg));
        if (acc) begin
            w = $urandom_range(0, 3);
            for (int k = 0; k < w; k++) begin
                MAC_DATA_VALID = 1'b1;
                MAC_DATA_IN    = 8'($urandom);
                MAC_DATA_LAST  = 1'($urandom);
                @(posedge ACLK); #1;
                chk({tag, "_hold_ready"}, 64'(MAC_DATA_READY), 64'd0);
                chk({tag, "_hold_valid"}, 64'(MESSAGE_VALID),  64'd1);
                chk({tag, "_hold_msg"},   64'(SENDER_MESSAGE), 64'(exp_msg));
            end
            MAC_DATA_VALID = 1'b0;
            MAC_DATA_LAST  = 1'b0;
            MESSAGE_ACCEPT = 1'b1;
            @(posedge ACLK); #1;
            MESSAGE_ACCEPT = 1'b0;
            chk({tag, "_acc_valid"}, 64'(MESSAGE_VALID),  64'd0);
            chk({tag, "_acc_ready"}, 64'(MAC_DATA_READY), 64'd1);
            chk({tag, "_acc_msg"},   64'(SENDER_MESSAGE), 64'(exp_msg));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1; MAC_DATA_IN = 8'h00; MAC_DATA_VALID = 1'b0; MAC_DATA_LAST = 1'b0;
        MAC_DATA_TUSER = 1'b0; MESSAGE_ACCEPT = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(posedge ACLK); #1;
        chk("rst_ready",   64'(MAC_DATA_READY),     64'd1);
        chk("rst_valid",   64'(MESSAGE_VALID),      64'd0);
        chk("rst_mac",     64'(SENDER_MAC_ADDRESS), 64'd0);
        chk("rst_ip",      64'(SENDER_IP_ADDRESS),  64'd0);
        chk("rst_msg",     64'(SENDER_MESSAGE),     64'd0);
        chk("rst_dropped", 64'(FRAMES_DROPPED),     64'd0);

        MESSAGE_ACCEPT = 1'b1;
        @(posedge ACLK); #1;
        MESSAGE_ACCEPT = 1'b0;
        chk("idle_accept_valid", 64'(MESSAGE_VALID),  64'd0);
        chk("idle_accept_ready", 64'(MAC_DATA_READY), 64'd1);

        build_frame(c_ACCEL_MAC, c_NOM_SRC, 16'h0800, 8'h45, c_NOM_IP, 10'h3FF, 60, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, "nominal");
        chk("nominal_spec_msg", 64'(exp_msg), 64'h3FF);

        build_frame(c_ACCEL_MAC ^ 48'h0000_0001_0000, 48'h0102030405A0, 16'h0800, 8'h45,
                    32'h11223344, 10'h0AA, 60, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, "bad_dest");

        build_frame(c_ACCEL_MAC, 48'h0102030405A1, 16'h0806, 8'h45, 32'h22334455, 10'h0BB, 60, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, "arp_type");
        build_frame(c_ACCEL_MAC, 48'hA1B2C3D4E5F6, 16'h0800, 8'h45, 32'h0A0B0C0D, 10'h155, 60, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, "b2b_after_arp");

        build_frame(c_ACCEL_MAC, 48'h0102030405A2, 16'h0800, 8'h45, 32'h33445566, 10'h0CC, 60, 1'b0, 1'b0);
        run_frame(1'b1, 1'b0, "tuser");

        build_frame(c_ACCEL_MAC, c_NOM_SRC, 16'h0800, 8'h45, c_NOM_IP, 10'h3FF, 20, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, "early_last");
        build_frame(48'hFFFF_FFFF_FFFF, 48'h112233445566, 16'h0800, 8'h45, 32'hC0A80101, 10'h2A5, 60, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, "bcast_after_early");

        build_frame(c_ACCEL_MAC, 48'h0102030405A3, 16'h0800, 8'h45, 32'h44556677, 10'h0DD, 35, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, "one_data_byte");
        build_frame(c_ACCEL_MAC, 48'h0102030405A4, 16'h0800, 8'h45, 32'h55667788, 10'h1E7, 36, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, "two_data_bytes");
        build_frame(c_ACCEL_MAC, 48'h0102030405A5, 16'h0800, 8'h45, 32'h66778899, 10'h321, 90, 1'b0, 1'b1);
        run_frame(1'b0, 1'b1, "long_frame");

        build_frame(c_ACCEL_MAC, 48'h0102030405A6, 16'h0800, 8'h45, 32'h778899AA, 10'h0EE, 60, 1'b1, 1'b0);
        run_frame(1'b0, 1'b0, "bad_csum");
        build_frame(c_ACCEL_MAC, 48'h0102030405A7, 16'h0800, 8'h45, 32'h8899AABB, 10'h0F0, 60, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, "good_csum");

        // Reset while data byte 1 is on the bus, then replay the nominal frame.
        build_frame(c_ACCEL_MAC, c_NOM_SRC, 16'h0800, 8'h45, c_NOM_IP, 10'h3FF, 35, 1'b0, 1'b0);
        send_frame(1'b0, 1'b0, 1'b1);
        MAC_DATA_IN = 8'hFF; MAC_DATA_VALID = 1'b1; ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0; MAC_DATA_VALID = 1'b0;
        exp_mac = '0; exp_ip = '0; exp_msg = '0; exp_dropped = 0;
        chk("midrst_ready",   64'(MAC_DATA_READY),     64'd1);
        chk("midrst_valid",   64'(MESSAGE_VALID),      64'd0);
        chk("midrst_mac",     64'(SENDER_MAC_ADDRESS), 64'd0);
        chk("midrst_ip",      64'(SENDER_IP_ADDRESS),  64'd0);
        chk("midrst_msg",     64'(SENDER_MESSAGE),     64'd0);
        chk("midrst_dropped", 64'(FRAMES_DROPPED),     64'd0);
        build_frame(c_ACCEL_MAC, c_NOM_SRC, 16'h0800, 8'h45, c_NOM_IP, 10'h3FF, 60, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, "replay");

        for (int n = 0; n < 40; n++) begin
            logic [47:0] d, s;
            logic [15:0] et;
            logic [7:0]  vh;
            int          sel, len, lsel;
            sel = $urandom_range(0, 7);
            d   = (sel >= 5) ? 48'hFFFF_FFFF_FFFF : c_ACCEL_MAC;
            if (sel == 6) d = c_ACCEL_MAC;
            if (sel >= 6) d[8*$urandom_range(0, 5) +: 8] = 8'($urandom);
            s    = {16'($urandom), 32'($urandom)};
            et   = ($urandom_range(0, 7) == 0) ? 16'h0806 : 16'h0800;
            vh   = ($urandom_range(0, 7) == 0) ? 8'h46 : 8'h45;
            lsel = $urandom_range(0, 5);
            len  = (lsel == 0) ? int'($urandom_range(1, 40)) :
                   (lsel == 1) ? int'($urandom_range(61, 90)) : 60;
            build_frame(d, s, et, vh, 32'($urandom), 10'($urandom), len,
                        $urandom_range(0, 7) == 0, 1'b1);
            run_frame($urandom_range(0, 7) == 0, 1'b1, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
